uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared constants and types for the UART blocks.
// Holds the receiver state enum, the oversampling ratio, the majority-vote
// sample positions inside a bit window and the data frame width.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int TICK_W     = $clog2(OVERSAMPLE);
    localparam int DATA_BITS  = 8;
    localparam int BIT_IDX_W  = 3;

    localparam logic [TICK_W-1:0] SAMPLE_IDX_0 = TICK_W'(7);
    localparam logic [TICK_W-1:0] SAMPLE_IDX_1 = TICK_W'(8);
    localparam logic [TICK_W-1:0] SAMPLE_IDX_2 = TICK_W'(9);
    localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // 2-of-3 vote used to reject a single-tick glitch inside a bit window
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
// Two-flop synchronizer for an asynchronous, idle-high input.
// Both flops reset to 1 so a reset never looks like a falling edge.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset
//   async_in - asynchronous input
//   sync_out - input resampled into the clk domain (2 clk latency)
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // Two back-to-back flops; the first may go metastable, the second settles it
    always_ff @(posedge clk) begin
        if (rst) begin
            meta     <= 1'b1;
            sync_out <= 1'b1;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// 8N1 UART receiver with 16x oversampling. Detects a start edge, votes each
// bit at window indices 7/8/9 and presents the byte with a one-clk strobe.
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset, dominates all inputs
//   baud16    - oversample enable, 16 pulses per bit time
//   rx_in     - asynchronous serial line, idle high
//   data_out  - last received byte, held until the next frame completes
//   rx_valid  - one-clk pulse: good frame, data_out updated
//   frame_err - one-clk pulse: stop bit low, data_out updated anyway
//   rx_busy   - high whenever the receiver is not idle
module uart_rx
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       baud16,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state;
    rx_state_t            state_next;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BIT_IDX_W-1:0] bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 samp_a;
    logic                 samp_b;
    logic                 bit_vote;
    logic                 armed;
    logic                 vote_now;
    logic                 frame_done;

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (rx_in),
        .sync_out (rx_s)
    );

    // The third vote sample is the live rx_s at index 9, so the result is
    // available on that same tick without waiting a further cycle
    assign vote_now = majority3(samp_a, samp_b, rx_s);
    assign rx_busy  = (state != RX_IDLE);

    // State register, advanced only on oversample ticks
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RX_IDLE;
        end else if (baud16) begin
            state <= state_next;
        end
    end

    // Next-state decode; frame_done marks the stop-bit vote tick
    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        case (state)
            RX_IDLE: begin
                if (!rx_s && armed) begin
                    state_next = RX_START;
                end
            end
            RX_START: begin
                if (tick_cnt == TICK_LAST) begin
                    state_next = bit_vote ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (tick_cnt == TICK_LAST && bit_idx == LAST_BIT) begin
                    state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (tick_cnt == SAMPLE_IDX_2) begin
                    state_next = RX_IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    // Tick/bit counters, vote samples, shift register and output registers.
    // The detection tick counts as index 0, so the counter is loaded with 1
    // on the way into START. The strobes default low every clk so they stay
    // one clk wide even when baud16 is held high.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            samp_a    <= 1'b0;
            samp_b    <= 1'b0;
            bit_vote  <= 1'b0;
            armed     <= 1'b1;
            data_out  <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (baud16) begin
                if (state == RX_IDLE) begin
                    tick_cnt <= (state_next == RX_START) ? TICK_W'(1) : '0;
                    bit_idx  <= '0;
                    if (rx_s) begin
                        armed <= 1'b1;
                    end
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                    if (tick_cnt == SAMPLE_IDX_0) begin
                        samp_a <= rx_s;
                    end
                    if (tick_cnt == SAMPLE_IDX_1) begin
                        samp_b <= rx_s;
                    end
                    if (tick_cnt == SAMPLE_IDX_2) begin
                        bit_vote <= vote_now;
                    end
                end

                if (state == RX_DATA && tick_cnt == TICK_LAST) begin
                    shift_reg <= {bit_vote, shift_reg[DATA_BITS-1:1]};
                    bit_idx   <= bit_idx + 1'b1;
                end

                // A low stop bit disarms detection until the line is seen
                // high again, so a held break yields a single error
                if (frame_done) begin
                    data_out <= shift_reg;
                    if (vote_now) begin
                        rx_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                        armed     <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
// Self-checking bench for uart_rx: table of frames, hand-written corner
// sequences and randomized frames checked against an expected-pulse queue.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud16;
    logic       rx_in;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .baud16    (baud16),
        .rx_in     (rx_in),
        .data_out  (data_out),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_valid;
        logic [7:0] data;
    } pulse_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         gap_bits;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    int     tests = 0;
    int     fails = 0;
    int     tick_div = 1;
    pulse_t got_q[$];
    pulse_t exp_q[$];
    int     overlap_cnt = 0;
    int     double_cnt = 0;
    logic   prev_pulse = 1'b0;
    vec_t   vecs[5];

    // Record every strobe together with the byte presented alongside it
    always @(negedge clk) begin
        if (rx_valid || frame_err) begin
            got_q.push_back('{is_valid: rx_valid, data: data_out});
        end
        if (rx_valid && frame_err) begin
            overlap_cnt <= overlap_cnt + 1;
        end
        if ((rx_valid || frame_err) && prev_pulse) begin
            double_cnt <= double_cnt + 1;
        end
        prev_pulse <= rx_valid || frame_err;
    end

    // Oversample enable: one clk high every tick_div clks
    initial begin
        int cnt;
        cnt = 0;
        baud16 = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            cnt++;
            baud16 = (tick_div <= 1) || ((cnt % tick_div) == 0);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic hold(input logic v, input int nclk);
        rx_in = v;
        repeat (nclk) @(posedge clk);
        #1;
    endtask

    // Drive one ideal 8N1 frame at the current oversample rate, then idle
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input int gap_bits);
        int bl;
        bl = 16 * tick_div;
        hold(1'b0, bl);
        for (int i = 0; i < 8; i++) begin
            hold(b[i], bl);
        end
        hold(stop_bit, bl);
        if (gap_bits > 0) begin
            hold(1'b1, gap_bits * bl);
        end
    endtask

    // Frame with a one-clk inverted glitch at offset goff of data bit gbit
    task automatic applyGlitchFrame(input logic [7:0] b, input int gbit, input int goff);
        hold(1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if (i == gbit) begin
                hold(b[i], goff);
                hold(~b[i], 1);
                hold(b[i], 16 - goff - 1);
            end else begin
                hold(b[i], 16);
            end
        end
        hold(1'b1, 16);
        hold(1'b1, 32);
    endtask

    // Reference: a frame yields one pulse carrying its byte, valid iff the
    // stop bit is high
    task automatic expectFrame(input logic [7:0] b, input logic stop_bit);
        exp_q.push_back('{is_valid: stop_bit, data: b});
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while (got_q.size() < exp_q.size() && c < 4000) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput({name, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            pulse_t g;
            pulse_t e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checkOutput({name, "_kind"}, g.is_valid, e.is_valid);
            checkOutput({name, "_data"}, g.data, e.data);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{data: 8'h00, stop_bit: 1'b1, gap_bits: 0, exp_valid: 1'b1, exp_data: 8'h00};
        vecs[1] = '{data: 8'hFF, stop_bit: 1'b1, gap_bits: 0, exp_valid: 1'b1, exp_data: 8'hFF};
        vecs[2] = '{data: 8'h3C, stop_bit: 1'b1, gap_bits: 2, exp_valid: 1'b1, exp_data: 8'h3C};
        vecs[3] = '{data: 8'h5A, stop_bit: 1'b0, gap_bits: 2, exp_valid: 1'b0, exp_data: 8'h5A};
        vecs[4] = '{data: 8'h81, stop_bit: 1'b1, gap_bits: 1, exp_valid: 1'b1, exp_data: 8'h81};

        // Reset values
        rst = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_data", data_out, 8'h00);
        checkOutput("reset_valid", rx_valid, 1'b0);
        checkOutput("reset_err", frame_err, 1'b0);
        checkOutput("reset_busy", rx_busy, 1'b0);
        @(posedge clk);
        #1;

        // 0xA5 with exact strobe timing: drop seen at tick 3 clks later,
        // completion 153 ticks after that, visible the following clk
        expectFrame(8'hA5, 1'b1);
        fork
            applyStimulus(8'hA5, 1'b1, 2);
            begin
                repeat (155) @(posedge clk);
                @(negedge clk);
                checkOutput("a5_early", rx_valid, 1'b0);
                checkOutput("a5_busy", rx_busy, 1'b1);
                @(posedge clk);
                @(negedge clk);
                checkOutput("a5_valid", rx_valid, 1'b1);
                checkOutput("a5_data", data_out, 8'hA5);
                checkOutput("a5_idle", rx_busy, 1'b0);
                @(negedge clk);
                checkOutput("a5_width", rx_valid, 1'b0);
            end
        join
        drain("a5");

        // Table: back-to-back frames, a framing error, spaced frames
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].data, vecs[i].stop_bit, vecs[i].gap_bits);
            exp_q.push_back('{is_valid: vecs[i].exp_valid, data: vecs[i].exp_data});
        end
        hold(1'b1, 32);
        drain("table");

        // Start glitch: 3 clks low is a false start ending at index 15
        fork
            begin
                hold(1'b0, 3);
                hold(1'b1, 48);
            end
            begin
                repeat (17) @(posedge clk);
                @(negedge clk);
                checkOutput("glitch_busy", rx_busy, 1'b1);
                @(posedge clk);
                @(negedge clk);
                checkOutput("glitch_idle", rx_busy, 1'b0);
            end
        join
        drain("glitch");

        // Break: 0x55 with low stop, line then held low 40 bit times
        expectFrame(8'h55, 1'b0);
        applyStimulus(8'h55, 1'b0, 0);
        hold(1'b0, 40 * 16);
        checkOutput("break_busy", rx_busy, 1'b0);
        checkOutput("break_data", data_out, 8'h55);
        drain("break");
        hold(1'b1, 32);

        // Reset during data bit 4 of 0x81, then a clean 0x81
        hold(1'b0, 16);
        for (int i = 0; i < 4; i++) begin
            hold(((i == 0) ? 1'b1 : 1'b0), 16);
        end
        hold(1'b0, 8);
        rst = 1'b1;
        rx_in = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_data", data_out, 8'h00);
        checkOutput("rst_busy", rx_busy, 1'b0);
        checkOutput("rst_valid", rx_valid, 1'b0);
        checkOutput("rst_err", frame_err, 1'b0);
        @(posedge clk);
        #1;
        hold(1'b1, 32);
        drain("rst_abort");
        expectFrame(8'h81, 1'b1);
        applyStimulus(8'h81, 1'b1, 2);
        drain("rst_clean");

        // One-clk low glitch at index 8 of data bit 2 in 0xFF
        expectFrame(8'hFF, 1'b1);
        applyGlitchFrame(8'hFF, 2, 8);
        drain("vote");

        // Randomized frames at varying oversample rates
        for (int i = 0; i < 12; i++) begin
            logic [7:0] b;
            logic       sb;
            tick_div = $urandom_range(1, 3);
            b = 8'($urandom);
            sb = ($urandom_range(0, 4) != 0);
            expectFrame(b, sb);
            applyStimulus(b, sb, $urandom_range(1, 3));
        end
        tick_div = 1;
        hold(1'b1, 64);
        drain("random");

        checkOutput("pulse_overlap", overlap_cnt, 0);
        checkOutput("pulse_width", double_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
